// File: rtl/reg_dump_pkg.sv
// Shared constants and types for the register-file dump engine.
package reg_dump_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;
  // Settle counter width covers the legal SETTLE_CYCLES range 1..15.
  localparam int unsigned CTR_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SEND   = 2'd2,
    ST_FIN    = 2'd3
  } dump_state_t;

  // Next register number, wrapping from NUM_REGS-1 back to 0.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(NUM_REGS - 1)) begin
      next_addr = '0;
    end else begin
      next_addr = a + ADDR_W'(1);
    end
  endfunction

endpackage

// File: rtl/reg_dump_settle_ctr.sv
// Loadable down-counter with a registered zero flag; counts the settle wait.
module reg_dump_settle_ctr
  import reg_dump_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CTR_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CTR_W-1:0] r_count;
  logic             r_zero;

  // Load takes priority over decrement; the count holds once it reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_zero  <= 1'b1;
    end else if (i_load) begin
      r_count <= i_load_val;
      r_zero  <= (i_load_val == CTR_W'(0));
    end else if (i_dec && !r_zero) begin
      r_count <= r_count - CTR_W'(1);
      r_zero  <= (r_count == CTR_W'(1));
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/reg_dump_unit.sv
// Register-file dump engine: walks a register range through the asynchronous
// read port, waits a settle time per address and streams (addr, value) beats.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] FIRST_ADDR,
  input  logic [ADDR_W-1:0] LAST_ADDR,
  output logic [ADDR_W-1:0] RDADDRESS,
  input  logic [DATA_W-1:0] RDDATA,
  output logic [DATA_W-1:0] DOUT,
  output logic [ADDR_W-1:0] DOUT_ADDR,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              BUSY,
  output logic              DONE
);

  // Counter reload value: SETTLE lasts SETTLE_CYCLES cycles including the capture edge.
  localparam logic [CTR_W-1:0] SETTLE_LOAD = CTR_W'(SETTLE_CYCLES - 1);

  dump_state_t       r_state;
  // The read address register doubles as the latched first address of the range.
  logic [ADDR_W-1:0] r_rdaddr;
  logic [ADDR_W-1:0] r_last;
  logic [DATA_W-1:0] r_dout;
  logic [ADDR_W-1:0] r_dout_addr;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic w_beat_taken;
  logic w_at_last;
  logic w_ctr_load;
  logic w_ctr_dec;
  logic w_ctr_zero;

  assign w_beat_taken = r_valid & DOUT_READY;
  assign w_at_last    = (r_rdaddr == r_last);

  // Counter control: reload on every new address, count down only while settling.
  always_comb begin
    w_ctr_load = 1'b0;
    w_ctr_dec  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ctr_load = START;
      end
      ST_SETTLE: begin
        w_ctr_dec = 1'b1;
      end
      ST_SEND: begin
        w_ctr_load = w_beat_taken & ~w_at_last;
      end
      ST_FIN: begin
        w_ctr_load = 1'b0;
      end
      default: begin
        w_ctr_load = 1'b0;
        w_ctr_dec  = 1'b0;
      end
    endcase
  end

  reg_dump_settle_ctr u_settle_ctr (
    .clk        (CLK),
    .rst        (RESET),
    .i_load     (w_ctr_load),
    .i_load_val (SETTLE_LOAD),
    .i_dec      (w_ctr_dec),
    .o_zero     (w_ctr_zero)
  );

  // Dump sequencer and all registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_rdaddr    <= '0;
      r_last      <= '0;
      r_dout      <= '0;
      r_dout_addr <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_rdaddr <= FIRST_ADDR;
            r_last   <= LAST_ADDR;
            r_busy   <= 1'b1;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Capture whatever the read port shows on the final settle edge.
          if (w_ctr_zero) begin
            r_dout      <= RDDATA;
            r_dout_addr <= r_rdaddr;
            r_valid     <= 1'b1;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_beat_taken) begin
            r_valid <= 1'b0;
            if (w_at_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_rdaddr <= next_addr(r_rdaddr);
              r_state  <= ST_SETTLE;
            end
          end
        end
        ST_FIN: begin
          // START is deliberately not sampled here.
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign RDADDRESS  = r_rdaddr;
  assign DOUT       = r_dout;
  assign DOUT_ADDR  = r_dout_addr;
  assign DOUT_VALID = r_valid;
  assign BUSY       = r_busy;
  assign DONE       = r_done;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: a main instance with SETTLE_CYCLES=1 and a
// second instance with SETTLE_CYCLES=3 for settle timing.
module tb_reg_dump_unit;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic       START3;
  logic [2:0] FIRST_ADDR;
  logic [2:0] LAST_ADDR;
  logic       DOUT_READY;

  logic [2:0] RDADDRESS,  RDADDRESS3;
  logic [7:0] RDDATA,     RDDATA3;
  logic [7:0] DOUT,       DOUT3;
  logic [2:0] DOUT_ADDR,  DOUT_ADDR3;
  logic       DOUT_VALID, DOUT_VALID3;
  logic       BUSY,       BUSY3;
  logic       DONE,       DONE3;

  logic [7:0] regs [0:7];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt = 0;
  int q_addr[$], q_data[$], q_cyc[$];
  int q3_addr[$], q3_data[$], q3_cyc[$];

  assign RDDATA  = regs[RDADDRESS];
  assign RDDATA3 = regs[RDADDRESS3];

  reg_dump_unit #(.SETTLE_CYCLES(1)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .FIRST_ADDR(FIRST_ADDR), .LAST_ADDR(LAST_ADDR),
    .RDADDRESS(RDADDRESS), .RDDATA(RDDATA),
    .DOUT(DOUT), .DOUT_ADDR(DOUT_ADDR), .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY), .BUSY(BUSY), .DONE(DONE)
  );

  reg_dump_unit #(.SETTLE_CYCLES(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .START(START3),
    .FIRST_ADDR(FIRST_ADDR), .LAST_ADDR(LAST_ADDR),
    .RDADDRESS(RDADDRESS3), .RDDATA(RDDATA3),
    .DOUT(DOUT3), .DOUT_ADDR(DOUT_ADDR3), .DOUT_VALID(DOUT_VALID3),
    .DOUT_READY(DOUT_READY), .BUSY(BUSY3), .DONE(DONE3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // posedge counter
  always @(posedge CLK) cyc <= cyc + 1;

  // Beat monitor: inputs only change #1 after a posedge, so VALID&READY at the
  // negedge means the beat transfers on the following posedge.
  always @(negedge CLK) begin
    if (DOUT_VALID === 1'b1 && DOUT_READY === 1'b1) begin
      q_addr.push_back(int'(DOUT_ADDR));
      q_data.push_back(int'(DOUT));
      q_cyc.push_back(cyc);
    end
    if (DOUT_VALID3 === 1'b1 && DOUT_READY === 1'b1) begin
      q3_addr.push_back(int'(DOUT_ADDR3));
      q3_data.push_back(int'(DOUT3));
      q3_cyc.push_back(cyc);
    end
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_q();
    q_addr.delete(); q_data.delete(); q_cyc.delete();
    q3_addr.delete(); q3_data.delete(); q3_cyc.delete();
  endtask

  // Returns s = number of the posedge that accepted START.
  task automatic pulse_start(output int s);
    tick();
    START = 1'b1;
    tick();
    s = cyc;
    START = 1'b0;
  endtask

  task automatic pulse_start3(output int s);
    tick();
    START3 = 1'b1;
    tick();
    s = cyc;
    START3 = 1'b0;
  endtask

  task automatic wait_done(input bit use3, input int budget, output bit found, output int dcyc);
    found = 1'b0;
    dcyc = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge CLK);
      if ((use3 ? DONE3 : DONE) === 1'b1) begin
        found = 1'b1;
        dcyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #1 RESET = 1'b1;
    repeat (2) @(negedge CLK);
    vecs++;
    if ({RDADDRESS, DOUT, DOUT_ADDR, DOUT_VALID, BUSY, DONE} !== 17'h0) begin
      errs++;
      $display("FAIL reset_outputs: got rdaddr=%0d dout=%0h daddr=%0d v=%b busy=%b done=%b, want all 0",
               RDADDRESS, DOUT, DOUT_ADDR, DOUT_VALID, BUSY, DONE);
    end
    tick();
    RESET = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_full_dump();
    int s, dc;
    bit found;
    for (int i = 0; i < 8; i++) regs[i] = 8'(10 + i);
    FIRST_ADDR = 3'd0; LAST_ADDR = 3'd7; DOUT_READY = 1'b1;
    clear_q();
    pulse_start(s);
    @(negedge CLK);
    vecs++;
    if (BUSY !== 1'b1 || RDADDRESS !== 3'd0) begin
      errs++;
      $display("FAIL full_start: got busy=%b rdaddr=%0d, want busy=1 rdaddr=0", BUSY, RDADDRESS);
    end
    wait_done(1'b0, 60, found, dc);
    vecs++;
    if (!found || dc - s !== 16) begin
      errs++;
      $display("FAIL full_latency: got done=%b after %0d cycles, want done after 16", found, dc - s);
    end
    @(negedge CLK);
    vecs++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      errs++;
      $display("FAIL full_after_fin: got done=%b busy=%b, want 0 0", DONE, BUSY);
    end
    vecs++;
    if (q_addr.size() !== 8) begin
      errs++;
      $display("FAIL full_count: got %0d beats, want 8", q_addr.size());
    end
    for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
      vecs++;
      if (q_addr[i] !== i || q_data[i] !== 10 + i || q_cyc[i] !== s + 1 + 2 * i) begin
        errs++;
        $display("FAIL full_beat%0d: got addr=%0d data=%0d cyc=%0d, want addr=%0d data=%0d cyc=%0d",
                 i, q_addr[i], q_data[i], q_cyc[i], i, 10 + i, s + 1 + 2 * i);
      end
    end
    if (q_cyc.size() == 8) begin
      vecs++;
      if (dc !== q_cyc[7] + 1) begin
        errs++;
        $display("FAIL full_done_pos: got done cyc=%0d, want %0d", dc, q_cyc[7] + 1);
      end
    end
  endtask

  task automatic test_wrap();
    int s, dc;
    bit found;
    int exp_a[4] = '{6, 7, 0, 1};
    tick();
    FIRST_ADDR = 3'd6; LAST_ADDR = 3'd1;
    clear_q();
    pulse_start(s);
    wait_done(1'b0, 40, found, dc);
    vecs++;
    if (!found || q_addr.size() !== 4) begin
      errs++;
      $display("FAIL wrap_count: got done=%b beats=%0d, want done=1 beats=4", found, q_addr.size());
    end
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      vecs++;
      if (q_addr[i] !== exp_a[i] || q_data[i] !== 10 + exp_a[i]) begin
        errs++;
        $display("FAIL wrap_beat%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                 i, q_addr[i], q_data[i], exp_a[i], 10 + exp_a[i]);
      end
    end
    regs[3] = 8'hA5;
    FIRST_ADDR = 3'd3; LAST_ADDR = 3'd3;
    clear_q();
    pulse_start(s);
    wait_done(1'b0, 20, found, dc);
    vecs++;
    if (!found || dc - s !== 2 || q_addr.size() !== 1) begin
      errs++;
      $display("FAIL single_count: got done=%b lat=%0d beats=%0d, want done=1 lat=2 beats=1",
               found, dc - s, q_addr.size());
    end
    if (q_addr.size() > 0) begin
      vecs++;
      if (q_addr[0] !== 3 || q_data[0] !== 8'hA5) begin
        errs++;
        $display("FAIL single_beat: got addr=%0d data=%0h, want addr=3 data=a5", q_addr[0], q_data[0]);
      end
    end
    regs[3] = 8'd13;
  endtask

  task automatic test_backpressure();
    int s, dc;
    bit found;
    tick();
    DOUT_READY = 1'b0;
    FIRST_ADDR = 3'd0; LAST_ADDR = 3'd2;
    clear_q();
    pulse_start(s);
    @(negedge CLK);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      vecs++;
      if (DOUT_VALID !== 1'b1 || DOUT !== 8'd10 || DOUT_ADDR !== 3'd0 || RDADDRESS !== 3'd0) begin
        errs++;
        $display("FAIL stall%0d: got v=%b dout=%0d daddr=%0d rdaddr=%0d, want v=1 dout=10 daddr=0 rdaddr=0",
                 k, DOUT_VALID, DOUT, DOUT_ADDR, RDADDRESS);
      end
    end
    tick();
    DOUT_READY = 1'b1;
    wait_done(1'b0, 40, found, dc);
    vecs++;
    if (!found || dc !== s + 12 || q_addr.size() !== 3) begin
      errs++;
      $display("FAIL bp_done: got done=%b cyc=%0d beats=%0d, want done=1 cyc=%0d beats=3",
               found, dc, q_addr.size(), s + 12);
    end
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      vecs++;
      if (q_addr[i] !== i || q_data[i] !== 10 + i) begin
        errs++;
        $display("FAIL bp_beat%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                 i, q_addr[i], q_data[i], i, 10 + i);
      end
    end
    if (q_cyc.size() > 0) begin
      vecs++;
      if (q_cyc[0] !== s + 7) begin
        errs++;
        $display("FAIL bp_release: got first transfer cyc=%0d, want %0d", q_cyc[0], s + 7);
      end
    end
  endtask

  task automatic test_settle();
    int s, dc;
    bit found;
    tick();
    regs[2] = 8'd12;
    FIRST_ADDR = 3'd2; LAST_ADDR = 3'd4; DOUT_READY = 1'b1;
    clear_q();
    pulse_start3(s);
    tick();
    tick();
    regs[2] = 8'h5C;
    @(negedge CLK);
    vecs++;
    if (RDADDRESS3 !== 3'd2 || BUSY3 !== 1'b1 || DOUT_VALID3 !== 1'b0) begin
      errs++;
      $display("FAIL settle_hold: got rdaddr=%0d busy=%b v=%b, want rdaddr=2 busy=1 v=0",
               RDADDRESS3, BUSY3, DOUT_VALID3);
    end
    wait_done(1'b1, 60, found, dc);
    vecs++;
    if (!found || dc !== s + 12 || q3_addr.size() !== 3) begin
      errs++;
      $display("FAIL settle_done: got done=%b cyc=%0d beats=%0d, want done=1 cyc=%0d beats=3",
               found, dc, q3_addr.size(), s + 12);
    end
    for (int i = 0; i < 3 && i < q3_addr.size(); i++) begin
      vecs++;
      if (q3_addr[i] !== 2 + i || q3_data[i] !== (i == 0 ? 8'h5C : 12 + i) || q3_cyc[i] !== s + 3 + 4 * i) begin
        errs++;
        $display("FAIL settle_beat%0d: got addr=%0d data=%0h cyc=%0d, want addr=%0d data=%0h cyc=%0d",
                 i, q3_addr[i], q3_data[i], q3_cyc[i], 2 + i, (i == 0 ? 8'h5C : 12 + i), s + 3 + 4 * i);
      end
    end
    regs[2] = 8'd12;
  endtask

  task automatic test_start_busy();
    int s, dc, d0;
    bit found;
    tick();
    d0 = done_cnt;
    FIRST_ADDR = 3'd0; LAST_ADDR = 3'd3;
    clear_q();
    pulse_start(s);
    repeat (3) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (3) tick();
    START = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    vecs++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || q_addr.size() !== 4) begin
      errs++;
      $display("FAIL busy_fin: got done=%b busy=%b beats=%0d, want done=1 busy=0 beats=4",
               DONE, BUSY, q_addr.size());
    end
    @(negedge CLK);
    vecs++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      errs++;
      $display("FAIL busy_fin_ignored: got done=%b busy=%b, want 0 0", DONE, BUSY);
    end
    @(negedge CLK);
    vecs++;
    if (BUSY !== 1'b1 || RDADDRESS !== 3'd0) begin
      errs++;
      $display("FAIL busy_restart: got busy=%b rdaddr=%0d, want busy=1 rdaddr=0", BUSY, RDADDRESS);
    end
    tick();
    START = 1'b0;
    wait_done(1'b0, 40, found, dc);
    vecs++;
    if (!found || dc !== s + 18 || q_addr.size() !== 8) begin
      errs++;
      $display("FAIL busy_second: got done=%b cyc=%0d beats=%0d, want done=1 cyc=%0d beats=8",
               found, dc, q_addr.size(), s + 18);
    end
    for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
      vecs++;
      if (q_addr[i] !== i % 4 || q_data[i] !== 10 + i % 4) begin
        errs++;
        $display("FAIL busy_beat%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                 i, q_addr[i], q_data[i], i % 4, 10 + i % 4);
      end
    end
    tick();
    @(negedge CLK);
    vecs++;
    if (done_cnt !== d0 + 2) begin
      errs++;
      $display("FAIL busy_done_pulses: got %0d, want %0d", done_cnt - d0, 2);
    end
  endtask

  task automatic test_reset_mid();
    int s, dc, d0;
    bit found;
    tick();
    d0 = done_cnt;
    FIRST_ADDR = 3'd0; LAST_ADDR = 3'd7;
    clear_q();
    pulse_start(s);
    repeat (8) @(negedge CLK);
    vecs++;
    if (DOUT_VALID !== 1'b1 || DOUT_ADDR !== 3'd3) begin
      errs++;
      $display("FAIL rst_mid_pre: got v=%b daddr=%0d, want v=1 daddr=3", DOUT_VALID, DOUT_ADDR);
    end
    #1 RESET = 1'b1;
    #1;
    vecs++;
    if ({RDADDRESS, DOUT, DOUT_ADDR, DOUT_VALID, BUSY, DONE} !== 17'h0) begin
      errs++;
      $display("FAIL rst_mid_async: got rdaddr=%0d dout=%0h daddr=%0d v=%b busy=%b done=%b, want all 0",
               RDADDRESS, DOUT, DOUT_ADDR, DOUT_VALID, BUSY, DONE);
    end
    repeat (2) @(negedge CLK);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    vecs++;
    if (done_cnt !== d0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_nodone: got pulses=%0d done=%b busy=%b, want 0 0 0", done_cnt - d0, DONE, BUSY);
    end
    clear_q();
    pulse_start(s);
    wait_done(1'b0, 60, found, dc);
    vecs++;
    if (!found || dc - s !== 16 || q_addr.size() !== 8) begin
      errs++;
      $display("FAIL rst_fresh: got done=%b lat=%0d beats=%0d, want done=1 lat=16 beats=8",
               found, dc - s, q_addr.size());
    end
    for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
      vecs++;
      if (q_addr[i] !== i || q_data[i] !== 10 + i) begin
        errs++;
        $display("FAIL rst_fresh_beat%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                 i, q_addr[i], q_data[i], i, 10 + i);
      end
    end
  endtask

  initial begin
    START = 1'b0; START3 = 1'b0;
    FIRST_ADDR = 3'd0; LAST_ADDR = 3'd0; DOUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 8'(10 + i);
    test_reset();
    test_full_dump();
    test_wrap();
    test_backpressure();
    test_settle();
    test_start_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
